// File: rtl/contador_descendente_carga_pkg.sv
// Shared definitions for the counter family: command opcodes and down-counter FSM encodings.
package contador_descendente_carga_pkg;

   localparam logic [1:0] OPC_HOLD = 2'b00;
   localparam logic [1:0] OPC_DEC  = 2'b01;
   localparam logic [1:0] OPC_LOAD = 2'b10;
   localparam logic [1:0] OPC_CLR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } st_e;

   function automatic logic is_legal_state(input logic [1:0] st);
      return (st != 2'b11);
   endfunction

endpackage

// File: rtl/contador_descendente_carga_if.sv
// Command/status bundle of the loadable down-counter; the master issues commands, the counter is the slave.
interface contador_descendente_carga_if #(parameter int n = 8);

   logic [1:0]   opc;
   logic [n-1:0] d;
   logic         auto_reload;
   logic [n-1:0] Q;
   logic         zero;
   logic         tc;
   logic [1:0]   state_o;

   modport master (
      output opc, d, auto_reload,
      input  Q, zero, tc, state_o
   );

   modport slave (
      input  opc, d, auto_reload,
      output Q, zero, tc, state_o
   );

endinterface

// File: rtl/contador_descendente_carga.sv
// Loadable down-counter/timer with terminal-count pulse and optional auto-reload of the last loaded value.
module contador_descendente_carga
   import contador_descendente_carga_pkg::*;
#(
   parameter int n = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   contador_descendente_carga_if.slave    bus
);

   localparam logic [n-1:0] CNT_ZERO = {n{1'b0}};
   localparam logic [n-1:0] CNT_ONE  = {{(n-1){1'b0}}, 1'b1};

   logic [n-1:0] q_r;
   logic [n-1:0] reload_r;
   st_e          state_r;
   logic         tc_r;

   logic [n-1:0] q_s;
   logic [n-1:0] reload_s;
   st_e          state_s;
   logic         tc_s;

   // Next-state / next-count decode from the current state and the command
   always_comb begin
      q_s      = q_r;
      reload_s = reload_r;
      state_s  = state_r;
      tc_s     = 1'b0;
      if (is_legal_state(state_r)) begin
         case (bus.opc)
            OPC_CLR: begin
               q_s      = CNT_ZERO;
               reload_s = CNT_ZERO;
               state_s  = ST_IDLE;
            end
            OPC_LOAD: begin
               q_s      = bus.d;
               reload_s = bus.d;
               if (bus.d != CNT_ZERO) begin
                  state_s = ST_RUN;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            OPC_DEC: begin
               case (state_r)
                  ST_RUN: begin
                     q_s = q_r - CNT_ONE;
                     if (q_r == CNT_ONE) begin
                        state_s = ST_DONE;
                        tc_s    = 1'b1;
                     end else begin
                        state_s = ST_RUN;
                     end
                  end
                  ST_DONE: begin
                     // Reload only when something non-zero was loaded; otherwise saturate at 0
                     if (bus.auto_reload && (reload_r != CNT_ZERO)) begin
                        q_s     = reload_r;
                        state_s = ST_RUN;
                     end else begin
                        q_s     = CNT_ZERO;
                        state_s = ST_DONE;
                     end
                  end
                  ST_IDLE: begin
                     q_s     = CNT_ZERO;
                     state_s = ST_IDLE;
                  end
                  default: begin
                     q_s     = CNT_ZERO;
                     state_s = ST_IDLE;
                  end
               endcase
            end
            OPC_HOLD: begin
               q_s = q_r;
            end
            default: begin
               q_s = q_r;
            end
         endcase
      end else begin
         q_s     = CNT_ZERO;
         state_s = ST_IDLE;
      end
   end

   // State, count, reload value and terminal-count pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r      <= CNT_ZERO;
         reload_r <= CNT_ZERO;
         state_r  <= ST_IDLE;
         tc_r     <= 1'b0;
      end else begin
         q_r      <= q_s;
         reload_r <= reload_s;
         state_r  <= state_s;
         tc_r     <= tc_s;
      end
   end

   assign bus.Q       = q_r;
   assign bus.zero    = (q_r == CNT_ZERO);
   assign bus.tc      = tc_r;
   assign bus.state_o = state_r;

endmodule

// File: tb/tb_contador_descendente_carga.sv
// Scoreboard bench for contador_descendente_carga: per-cycle expected outputs are queued with each command.
module tb_contador_descendente_carga;
   import contador_descendente_carga_pkg::*;

   typedef struct {
      string      tag;
      logic [7:0] q;
      logic       tc;
      logic [1:0] st;
   } exp_t;

   logic clk;
   logic rst;
   int   total_r;
   int   bad_r;
   exp_t sb_q[$];

   contador_descendente_carga_if #(.n(8)) bus ();

   contador_descendente_carga #(.n(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_r = total_r + 1;
      if (got !== exp) begin
         bad_r = bad_r + 1;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive one command, queue its expected result, clock it and compare the DUT against the queue head
   task automatic cyc(input string tag, input logic r, input logic [1:0] op, input logic [7:0] dv,
                      input logic ar, input logic [7:0] eq, input logic etc, input logic [1:0] est);
      exp_t e;
      rst             = r;
      bus.opc         = op;
      bus.d           = dv;
      bus.auto_reload = ar;
      e.tag = tag;
      e.q   = eq;
      e.tc  = etc;
      e.st  = est;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk({e.tag, ".Q"},     {24'd0, bus.Q},         {24'd0, e.q});
      chk({e.tag, ".tc"},    {31'd0, bus.tc},        {31'd0, e.tc});
      chk({e.tag, ".state"}, {30'd0, bus.state_o},   {30'd0, e.st});
      chk({e.tag, ".zero"},  {31'd0, bus.zero},      {31'd0, (e.q == 8'd0)});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      total_r = 0;
      bad_r   = 0;
      rst = 1'b1;
      bus.opc = 2'b00;
      bus.d = 8'h00;
      bus.auto_reload = 1'b0;
      @(negedge clk);

      // 1: reset overrides a load
      cyc("rst0", 1'b1, 2'b10, 8'h55, 1'b0, 8'h00, 1'b0, 2'b00);
      cyc("rst1", 1'b1, 2'b10, 8'h55, 1'b0, 8'h00, 1'b0, 2'b00);

      // 2: count down 3 and saturate
      cyc("ld3",  1'b0, 2'b10, 8'd3, 1'b0, 8'd3, 1'b0, 2'b01);
      cyc("d3a",  1'b0, 2'b01, 8'd0, 1'b0, 8'd2, 1'b0, 2'b01);
      cyc("d3b",  1'b0, 2'b01, 8'd0, 1'b0, 8'd1, 1'b0, 2'b01);
      cyc("d3c",  1'b0, 2'b01, 8'd0, 1'b0, 8'd0, 1'b1, 2'b10);
      cyc("d3d",  1'b0, 2'b01, 8'd0, 1'b0, 8'd0, 1'b0, 2'b10);

      // 3: periodic mode, period 3
      cyc("ar_ld", 1'b0, 2'b10, 8'd2, 1'b1, 8'd2, 1'b0, 2'b01);
      for (int p = 0; p < 3; p++) begin
         if (p > 0) cyc("ar_rl", 1'b0, 2'b01, 8'd0, 1'b1, 8'd2, 1'b0, 2'b01);
         cyc("ar_1", 1'b0, 2'b01, 8'd0, 1'b1, 8'd1, 1'b0, 2'b01);
         cyc("ar_0", 1'b0, 2'b01, 8'd0, 1'b1, 8'd0, 1'b1, 2'b10);
      end

      // 4: clear mid-count also clears the reload value
      cyc("ld5",  1'b0, 2'b10, 8'd5, 1'b0, 8'd5, 1'b0, 2'b01);
      cyc("d5a",  1'b0, 2'b01, 8'd0, 1'b0, 8'd4, 1'b0, 2'b01);
      cyc("d5b",  1'b0, 2'b01, 8'd0, 1'b0, 8'd3, 1'b0, 2'b01);
      cyc("hold", 1'b0, 2'b00, 8'd9, 1'b1, 8'd3, 1'b0, 2'b01);
      cyc("clr",  1'b0, 2'b11, 8'd0, 1'b0, 8'd0, 1'b0, 2'b00);
      cyc("clrd", 1'b0, 2'b01, 8'd0, 1'b1, 8'd0, 1'b0, 2'b00);

      // 5: load zero in DONE, then full-scale load
      cyc("ld1",  1'b0, 2'b10, 8'd1,  1'b0, 8'd1,  1'b0, 2'b01);
      cyc("d1",   1'b0, 2'b01, 8'd0,  1'b0, 8'd0,  1'b1, 2'b10);
      cyc("ld0",  1'b0, 2'b10, 8'd0,  1'b0, 8'd0,  1'b0, 2'b00);
      cyc("d0",   1'b0, 2'b01, 8'd0,  1'b1, 8'd0,  1'b0, 2'b00);
      cyc("ldff", 1'b0, 2'b10, 8'hFF, 1'b0, 8'hFF, 1'b0, 2'b01);
      cyc("dff",  1'b0, 2'b01, 8'd0,  1'b0, 8'hFE, 1'b0, 2'b01);

      // 6: reset mid-count, then hold
      cyc("ld4",  1'b0, 2'b10, 8'd4, 1'b0, 8'd4, 1'b0, 2'b01);
      cyc("d4",   1'b0, 2'b01, 8'd0, 1'b0, 8'd3, 1'b0, 2'b01);
      cyc("rstm", 1'b1, 2'b00, 8'd0, 1'b0, 8'd0, 1'b0, 2'b00);
      for (int h = 0; h < 3; h++) begin
         cyc("hld", 1'b0, 2'b00, 8'd7, 1'b1, 8'd0, 1'b0, 2'b00);
      end

      chk("sb_empty", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total_r, bad_r);
      $finish;
   end

endmodule
